// File: rtl/flex_serial_rx.sv
// flex_serial_rx: mid-bit sampling serial receiver with framing and overrun flags
module flex_serial_rx #(
  parameter int   DATA_BITS    = 8,
  parameter int   CLKS_PER_BIT = 10,
  parameter logic SHIFT_MSB    = 1'b0
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 serial_in,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 overrun_error,
  output logic                 framing_error
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_LOAD  = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);
  typedef enum logic [1:0] {IDLE, START_CHK, DATA, STOP} state_t;
  state_t               state, state_n;
  logic                 s_meta, s_in, s_prev;
  logic [TW-1:0]        timer, timer_n;
  logic [IW-1:0]        idx, idx_n;
  logic [DATA_BITS-1:0] shift_reg, shift_n, shifted, rx_data_n;
  logic                 ready_n, ovr_n, ferr_n, tick;
  assign tick    = (timer == '0);
  assign shifted = SHIFT_MSB ? {shift_reg[DATA_BITS-2:0], s_in} : {s_in, shift_reg[DATA_BITS-1:1]};
  // two-flop synchroniser plus previous-sample register for start-edge detection
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s_meta <= 1'b1;
      s_in   <= 1'b1;
      s_prev <= 1'b1;
    end else begin
      s_meta <= serial_in;
      s_in   <= s_meta;
      s_prev <= s_in;
    end
  end
  // state, counters, shift register and output flags
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      timer         <= '0;
      idx           <= '0;
      shift_reg     <= '0;
      rx_data       <= '1;
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      state         <= state_n;
      timer         <= timer_n;
      idx           <= idx_n;
      shift_reg     <= shift_n;
      rx_data       <= rx_data_n;
      data_ready    <= ready_n;
      overrun_error <= ovr_n;
      framing_error <= ferr_n;
    end
  end
  // next-state: a good stop loads the word and beats a same-cycle data_read
  always_comb begin
    state_n   = state;
    timer_n   = tick ? timer : timer - 1'b1;
    idx_n     = idx;
    shift_n   = shift_reg;
    rx_data_n = rx_data;
    ready_n   = data_ready & ~data_read;
    ovr_n     = overrun_error & ~data_read;
    ferr_n    = framing_error;
    case (state)
      IDLE: if (s_prev & ~s_in) begin
        state_n = START_CHK;
        timer_n = HALF_LOAD;
        ferr_n  = 1'b0;
      end
      START_CHK: if (tick) begin
        state_n = s_in ? IDLE : DATA;
        timer_n = BIT_LOAD;
        idx_n   = '0;
      end
      DATA: if (tick) begin
        shift_n = shifted;
        timer_n = BIT_LOAD;
        idx_n   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
        state_n = (idx == LAST_IDX) ? STOP : DATA;
      end
      STOP: if (tick) begin
        state_n = IDLE;
        if (s_in) begin
          rx_data_n = shift_reg;
          ready_n   = 1'b1;
          ovr_n     = (overrun_error | data_ready) & ~data_read;
        end else begin
          ferr_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_flex_serial_rx.sv
// tb_flex_serial_rx: scoreboard bench for flex_serial_rx with directed frames
module tb_flex_serial_rx;
  logic       clk = 1'b0;
  logic       n_rst, serial_in, data_read;
  logic [7:0] rx_data;
  logic       data_ready, overrun_error, framing_error;
  typedef struct {logic [7:0] d; logic rdy; logic ovr; logic ferr; int cyc;} exp_t;
  exp_t q[$];
  int tests = 0, fails = 0, cyc = 0;
  logic [7:0] prev_rx;
  logic       prev_rdy, prev_ovr, prev_ferr;

  flex_serial_rx #(.DATA_BITS(8), .CLKS_PER_BIT(10), .SHIFT_MSB(1'b0)) dut (
    .clk(clk), .n_rst(n_rst), .serial_in(serial_in), .data_read(data_read),
    .rx_data(rx_data), .data_ready(data_ready),
    .overrun_error(overrun_error), .framing_error(framing_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] st();
    return {21'd0, rx_data, data_ready, overrun_error, framing_error};
  endfunction

  function automatic logic [31:0] pk(input logic [7:0] d, input logic r, input logic o, input logic f);
    return {21'd0, d, r, o, f};
  endfunction

  // monitor: a new word, overrun or framing flag is an output event to score
  always @(negedge clk) begin
    if (n_rst === 1'b1 && ((data_ready && !prev_rdy) || rx_data !== prev_rx ||
        (overrun_error && !prev_ovr) || (framing_error && !prev_ferr))) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_event: got %h expected none", st());
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("frame_flags", st(), pk(e.d, e.rdy, e.ovr, e.ferr));
        chk("frame_cycle", cyc, e.cyc);
      end
    end
    prev_rx   = rx_data;
    prev_rdy  = data_ready;
    prev_ovr  = overrun_error;
    prev_ferr = framing_error;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // drive nbits of a frame; optionally pulse data_read on the stop-sample cycle
  task automatic send(input logic [7:0] d, input logic stop, input logic rd, input int nbits, input logic ferr_chk);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int i = 0; i < nbits * 10; i++) begin
      serial_in = fr[i/10];
      data_read = rd && i == 97;
      if (ferr_chk && i == 2) chk("ferr_before_edge", framing_error, 1);
      if (ferr_chk && i == 3) chk("ferr_clear_at_edge", framing_error, 0);
      @(posedge clk);
      #1;
    end
    serial_in = 1'b1;
    data_read = 1'b0;
  endtask

  task automatic frame(input logic [7:0] d, input logic stop, input logic rd, input logic ferr_chk, input exp_t e);
    e.cyc = cyc + 98;
    q.push_back(e);
    send(d, stop, rd, 10, ferr_chk);
    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
    idle(3);
  endtask

  task automatic pulse_read(input string name, input logic [7:0] d);
    data_read = 1'b1;
    @(posedge clk);
    #1;
    data_read = 1'b0;
    chk(name, st(), pk(d, 0, 0, 0));
  endtask

  initial begin
    n_rst = 1'b0;
    serial_in = 1'b1;
    data_read = 1'b0;
    idle(3);
    chk("reset_values", st(), pk(8'hFF, 0, 0, 0));
    n_rst = 1'b1;
    idle(3);
    frame(8'hA5, 1'b1, 1'b0, 1'b0, '{8'hA5, 1, 0, 0, 0});
    pulse_read("read_clears_a5", 8'hA5);
    serial_in = 1'b0;
    idle(3);
    serial_in = 1'b1;
    idle(30);
    chk("glitch_ignored", st(), pk(8'hA5, 0, 0, 0));
    frame(8'h11, 1'b1, 1'b0, 1'b0, '{8'h11, 1, 0, 0, 0});
    frame(8'h22, 1'b1, 1'b0, 1'b0, '{8'h22, 1, 1, 0, 0});
    pulse_read("read_clears_overrun", 8'h22);
    frame(8'h3C, 1'b0, 1'b0, 1'b0, '{8'h22, 0, 0, 1, 0});
    frame(8'h01, 1'b1, 1'b0, 1'b1, '{8'h01, 1, 0, 0, 0});
    frame(8'h66, 1'b1, 1'b1, 1'b0, '{8'h66, 1, 0, 0, 0});
    frame(8'h5B, 1'b0, 1'b0, 1'b0, '{8'h66, 1, 0, 1, 0});
    #2 n_rst = 1'b0;
    #1 chk("async_reset", st(), pk(8'hFF, 0, 0, 0));
    idle(2);
    n_rst = 1'b1;
    idle(3);
    send(8'h77, 1'b1, 1'b0, 5, 1'b0);
    n_rst = 1'b0;
    #1 chk("reset_mid_frame", st(), pk(8'hFF, 0, 0, 0));
    idle(2);
    n_rst = 1'b1;
    idle(5);
    frame(8'h5A, 1'b1, 1'b0, 1'b0, '{8'h5A, 1, 0, 0, 0});
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
